// File: rtl/multiplier_pkg.sv
// Shared definitions for the Booth multiplier control FSM and its datapath.
// Holds the FSM state encoding, the width of the state bus and the Booth
// pair codes, plus a tiny decode helper so both sides agree on what a
// {q[0], q_m1} pair means.
package multiplier_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } mulStateT;

   typedef enum logic [1:0] {
      BOOTH_NOP = 2'b00,
      BOOTH_ADD = 2'b01,
      BOOTH_SUB = 2'b10
   } boothOpT;

   // Radix-2 Booth recoding: 01 ends a run of ones (add), 10 starts one
   // (subtract), 00 and 11 are inside a run and need no arithmetic.
   function automatic boothOpT boothDecode(input logic qLsb, input logic qPrev);
      case ({qLsb, qPrev})
         2'b01:   return BOOTH_ADD;
         2'b10:   return BOOTH_SUB;
         default: return BOOTH_NOP;
      endcase
   endfunction

endpackage

// File: rtl/multiplier_booth_step.sv
// One combinational radix-2 Booth iteration.
// Ports:
//   acc      - current upper half of the partial product
//   q        - current lower half (remaining multiplier bits)
//   qM1      - Booth history bit
//   mcand    - latched multiplicand
//   accNext  - upper half after add/sub and arithmetic shift
//   qNext    - lower half after the shift
//   qM1Next  - history bit after the shift (old q[0])
module multiplier_booth_step
   import multiplier_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] q,
   input  logic             qM1,
   input  logic [WIDTH-1:0] mcand,
   output logic [WIDTH-1:0] accNext,
   output logic [WIDTH-1:0] qNext,
   output logic             qM1Next
);

   logic [WIDTH:0] accExt;
   logic [WIDTH:0] mcandExt;
   logic [WIDTH:0] sum;
   boothOpT        op;

   // The add/subtract runs one bit wider than the operands so that
   // subtracting the most-negative multiplicand cannot overflow; the extra
   // sign bit then falls naturally into acc through the arithmetic shift.
   always_comb begin
      accExt   = {acc[WIDTH-1], acc};
      mcandExt = {mcand[WIDTH-1], mcand};
      op       = boothDecode(q[0], qM1);
      sum      = accExt;
      case (op)
         BOOTH_ADD: sum = accExt + mcandExt;
         BOOTH_SUB: sum = accExt - mcandExt;
         default:   sum = accExt;
      endcase
      accNext = sum[WIDTH:1];
      qNext   = {sum[0], q[WIDTH-1:1]};
      qM1Next = q[0];
   end

endmodule

// File: rtl/multiplier_datapath.sv
// Radix-2 Booth signed multiplier datapath, slaved to the IDLE/EXEC/DONE
// control FSM. One Booth step is taken per EXEC cycle; the product is
// published only on completion and held while the FSM sits in DONE.
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous active-high reset
//   state        - FSM state (IDLE/EXEC/DONE, 2'b11 illegal)
//   op_start     - start strobe (loads operands in IDLE)
//   op_clear     - clear strobe (aborts in EXEC, drops result in DONE)
//   multiplicand - signed operand A, sampled at load
//   multiplier   - signed operand B, sampled at load
//   op_done      - single-cycle pulse, product complete
//   result       - signed 2*WIDTH product, valid while state==DONE
module multiplier_datapath
   import multiplier_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [STATE_W-1:0]   state,
   input  logic                 op_start,
   input  logic                 op_clear,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 op_done,
   output logic [2*WIDTH-1:0]   result
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic             qM1;
   logic [WIDTH-1:0] mcand;
   logic [CNT_W-1:0] cnt;
   logic             fin;

   logic [WIDTH-1:0] accNext;
   logic [WIDTH-1:0] qNext;
   logic             qM1Next;

   multiplier_booth_step #(
      .WIDTH (WIDTH)
   ) boothStep (
      .acc     (acc),
      .q       (q),
      .qM1     (qM1),
      .mcand   (mcand),
      .accNext (accNext),
      .qNext   (qNext),
      .qM1Next (qM1Next)
   );

   // All datapath registers. op_done defaults low every cycle so it can
   // only ever be a one-cycle pulse, raised by the final Booth step while
   // the FSM is still in EXEC; by the time the FSM reaches DONE it has
   // already fallen, so the FSM never sees a stale completion there.
   // result is touched only by load, completion, clear and reset so the
   // outside world never sees a partial product.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         q       <= '0;
         qM1     <= 1'b0;
         mcand   <= '0;
         cnt     <= '0;
         fin     <= 1'b0;
         op_done <= 1'b0;
         result  <= '0;
      end else begin
         op_done <= 1'b0;
         case (state)
            IDLE: begin
               if (op_start) begin
                  acc    <= '0;
                  q      <= multiplier;
                  qM1    <= 1'b0;
                  mcand  <= multiplicand;
                  cnt    <= '0;
                  fin    <= 1'b0;
                  result <= '0;
               end
            end
            EXEC: begin
               if (op_clear) begin
                  cnt    <= '0;
                  fin    <= 1'b0;
                  result <= '0;
               end else if (!fin) begin
                  acc <= accNext;
                  q   <= qNext;
                  qM1 <= qM1Next;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_STEP) begin
                     fin     <= 1'b1;
                     op_done <= 1'b1;
                     result  <= {accNext, qNext};
                  end
               end
            end
            DONE: begin
               if (op_clear) begin
                  result <= '0;
                  fin    <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench for multiplier_datapath. The bench plays the part of
// the control FSM itself, and compares every product against plain wide
// arithmetic on sign-extended operands.
module tb_multiplier_datapath;
   import multiplier_pkg::*;

   localparam int WIDTH = 64;

   logic                 clk;
   logic                 reset;
   logic [STATE_W-1:0]   state;
   logic                 op_start;
   logic                 op_clear;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 op_done;
   logic [2*WIDTH-1:0]   result;

   int total = 0;
   int bad   = 0;

   multiplier_datapath #(
      .WIDTH (WIDTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .state        (state),
      .op_start     (op_start),
      .op_clear     (op_clear),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .op_done      (op_done),
      .result       (result)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the low 2*WIDTH bits of the product of the sign-extended
   // operands is exactly the signed product.
   function automatic logic [2*WIDTH-1:0] refProduct(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] ea;
      logic [2*WIDTH-1:0] eb;
      ea = {{WIDTH{a[WIDTH-1]}}, a};
      eb = {{WIDTH{b[WIDTH-1]}}, b};
      return ea * eb;
   endfunction

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [2*WIDTH-1:0] observed,
                              input logic [2*WIDTH-1:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance one clock edge and settle just past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive state and strobes, then take one edge with them applied.
   task automatic applyStimulus(input logic [STATE_W-1:0] st, input logic start,
                                input logic clear);
      state    = st;
      op_start = start;
      op_clear = clear;
      tick();
   endtask

   // Full multiply from IDLE to DONE; leaves the FSM in DONE.
   task automatic runMultiply(input string tag, input logic [WIDTH-1:0] a,
                              input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] expected;
      int                 doneEdge;
      int                 pulses;
      logic               partialSeen;
      expected     = refProduct(a, b);
      doneEdge     = -1;
      pulses       = 0;
      partialSeen  = 1'b0;
      multiplicand = a;
      multiplier   = b;
      applyStimulus(IDLE, 1'b1, 1'b0);
      state    = EXEC;
      op_start = 1'b0;
      for (int e = 1; e <= WIDTH + 4; e++) begin
         tick();
         if (op_done) begin
            doneEdge = e;
            pulses++;
            break;
         end
         if (result !== '0) partialSeen = 1'b1;
      end
      checkOutput({tag, "/done_edge"}, (2*WIDTH)'(doneEdge), (2*WIDTH)'(WIDTH));
      checkOutput({tag, "/no_partial"}, (2*WIDTH)'(partialSeen), '0);
      checkOutput({tag, "/result_at_done"}, result, expected);
      tick();
      state = DONE;
      checkOutput({tag, "/done_fell"}, (2*WIDTH)'(op_done), '0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (op_done) pulses++;
      end
      checkOutput({tag, "/one_pulse"}, (2*WIDTH)'(pulses), (2*WIDTH)'(1));
      checkOutput({tag, "/result_held"}, result, expected);
   endtask

   // Clear out of DONE back to IDLE.
   task automatic leaveDone(input string tag);
      applyStimulus(DONE, 1'b0, 1'b1);
      checkOutput({tag, "/cleared"}, result, '0);
      state    = IDLE;
      op_clear = 1'b0;
   endtask

   // Watch a stretch of cycles and require op_done to stay low.
   task automatic expectQuiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (op_done) seen++;
      end
      checkOutput({tag, "/quiet"}, (2*WIDTH)'(seen), '0);
   endtask

   // Main sequence: reset, directed corners, abort/reset mid-operation,
   // DONE-state robustness, then a batch of random operand pairs.
   initial begin
      logic [2*WIDTH-1:0] held;
      logic [WIDTH-1:0]   ra;
      logic [WIDTH-1:0]   rb;
      logic [WIDTH-1:0]   minVal;
      minVal       = {1'b1, {(WIDTH-1){1'b0}}};
      reset        = 1'b1;
      state        = IDLE;
      op_start     = 1'b0;
      op_clear     = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      tick();
      tick();
      checkOutput("reset/result", result, '0);
      checkOutput("reset/op_done", (2*WIDTH)'(op_done), '0);
      reset = 1'b0;
      expectQuiet("idle_after_reset", 4);

      runMultiply("3x5", 64'd3, 64'd5);
      checkOutput("3x5/is_15", result, 128'd15);
      leaveDone("3x5");

      runMultiply("m2x7", -64'sd2, 64'd7);
      checkOutput("m2x7/value", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF2);
      leaveDone("m2x7");
      runMultiply("7xm2", 64'd7, -64'sd2);
      checkOutput("7xm2/value", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF2);
      leaveDone("7xm2");

      runMultiply("minxmin", minVal, minVal);
      checkOutput("minxmin/value", result, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
      leaveDone("minxmin");
      runMultiply("minx1", minVal, 64'd1);
      checkOutput("minx1/value", result, {{WIDTH{1'b1}}, minVal});
      leaveDone("minx1");

      // Abort in EXEC at cycle 10.
      multiplicand = 64'd123456789;
      multiplier   = -64'sd987654321;
      applyStimulus(IDLE, 1'b1, 1'b0);
      for (int i = 1; i < 10; i++) applyStimulus(EXEC, 1'b0, 1'b0);
      applyStimulus(EXEC, 1'b0, 1'b1);
      state    = IDLE;
      op_clear = 1'b0;
      checkOutput("abort/result", result, '0);
      checkOutput("abort/op_done", (2*WIDTH)'(op_done), '0);
      expectQuiet("abort", WIDTH + 4);
      runMultiply("6x7", 64'd6, 64'd7);
      checkOutput("6x7/is_42", result, 128'd42);
      leaveDone("6x7");

      // Reset for one cycle at EXEC cycle 20.
      multiplicand = -64'sd55555;
      multiplier   = 64'd77777;
      applyStimulus(IDLE, 1'b1, 1'b0);
      for (int i = 1; i < 20; i++) applyStimulus(EXEC, 1'b0, 1'b0);
      reset = 1'b1;
      applyStimulus(EXEC, 1'b0, 1'b0);
      reset = 1'b0;
      state = IDLE;
      checkOutput("midreset/result", result, '0);
      checkOutput("midreset/op_done", (2*WIDTH)'(op_done), '0);
      expectQuiet("midreset", WIDTH + 4);
      runMultiply("after_reset", -64'sd55555, 64'd77777);

      // op_start in DONE is ignored; illegal state freezes the datapath.
      held = result;
      applyStimulus(DONE, 1'b1, 1'b0);
      checkOutput("done_start/result", result, held);
      checkOutput("done_start/op_done", (2*WIDTH)'(op_done), '0);
      applyStimulus(2'b11, 1'b1, 1'b1);
      applyStimulus(2'b11, 1'b0, 1'b1);
      checkOutput("illegal/result", result, held);
      checkOutput("illegal/op_done", (2*WIDTH)'(op_done), '0);
      applyStimulus(DONE, 1'b0, 1'b0);
      checkOutput("illegal/back_done", result, held);
      leaveDone("after_reset");

      // Back-to-back without idle gaps.
      runMultiply("m1xm1_a", '1, '1);
      checkOutput("m1xm1_a/is_1", result, 128'd1);
      leaveDone("m1xm1_a");
      runMultiply("m1xm1_b", '1, '1);
      leaveDone("m1xm1_b");

      for (int n = 0; n < 16; n++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (n % 4 == 1) ra = ra >> $urandom_range(1, 60);
         if (n % 4 == 2) rb = -(rb >> $urandom_range(1, 60));
         runMultiply($sformatf("rand%0d", n), ra, rb);
         leaveDone($sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a stimulus path ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
